// File: rtl/servo_cmd_ramp_if.sv
// Command-stage bundle between the select input and the two-channel PWM generator.
// The ramp block is the slave; the stimulus/consumer side is the master.
interface servo_cmd_ramp_if;
  logic        sel_raw;
  logic [17:0] duty0;
  logic [17:0] duty1;
  logic        frame_tick;
  logic        busy;

  modport master (
    output sel_raw,
    input  duty0,
    input  duty1,
    input  frame_tick,
    input  busy
  );

  modport slave (
    input  sel_raw,
    output duty0,
    output duty1,
    output frame_tick,
    output busy
  );
endinterface

// File: rtl/servo_cmd_ramp.sv
// Debounced two-position servo command: mirrored duty targets, ramped by at most STEP per
// PWM frame, with duty updates only on frame boundaries.
module servo_cmd_ramp #(
  parameter int unsigned FRAME_LEN = 240000,
  parameter int unsigned DUTY_A    = 20399,
  parameter int unsigned DUTY_B    = 15599,
  parameter int unsigned STEP      = 200,
  parameter int unsigned DEBOUNCE  = 120000
) (
  input logic             clk,
  input logic             rst_n,
  servo_cmd_ramp_if.slave bus
);

  localparam int unsigned FcW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned DbW = $clog2(DEBOUNCE + 1);
  localparam logic [FcW-1:0] FcLast = FcW'(FRAME_LEN - 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
  localparam logic [17:0]    DutyAV = 18'(DUTY_A);
  localparam logic [17:0]    DutyBV = 18'(DUTY_B);
  localparam logic [17:0]    StepV  = 18'(STEP);

  typedef enum logic {StIdle, StRamp} state_e;

  state_e         state_q, state_d;
  logic [1:0]     sync_q;
  logic           sel_db_q, sel_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;
  logic [17:0]    duty0_q, duty0_d, duty1_q, duty1_d;
  logic           tick_q;
  logic           sel_sync, wrap;
  logic [17:0]    t0, t1;

  // Clamp to the target so the final step never overshoots.
  function automatic logic [17:0] step_toward(input logic [17:0] cur, input logic [17:0] tgt);
    logic [17:0] r;
    if (tgt > cur) r = ((tgt - cur) > StepV) ? cur + StepV : tgt;
    else           r = ((cur - tgt) > StepV) ? cur - StepV : tgt;
    return r;
  endfunction

  always_comb begin
    sel_sync = sync_q[1];
    sel_db_d = sel_db_q;
    db_cnt_d = '0;
    if (sel_sync != sel_db_q) begin
      if (db_cnt_q == DbLast) sel_db_d = sel_sync;
      else                    db_cnt_d = db_cnt_q + 1'b1;
    end

    wrap   = (fcnt_q == FcLast);
    fcnt_d = wrap ? '0 : fcnt_q + 1'b1;

    // Targets follow the registered select, so a select change on a wrap edge uses old targets.
    t0 = sel_db_q ? DutyBV : DutyAV;
    t1 = sel_db_q ? DutyAV : DutyBV;

    duty0_d = duty0_q;
    duty1_d = duty1_q;
    if (wrap) begin
      duty0_d = step_toward(duty0_q, t0);
      duty1_d = step_toward(duty1_q, t1);
    end

    state_d = state_q;
    if (sel_db_d != sel_db_q) begin
      state_d = StRamp;
    end else if (state_q == StRamp && wrap && duty0_d == t0 && duty1_d == t1) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sync_q   <= '0;
      sel_db_q <= 1'b0;
      db_cnt_q <= '0;
      fcnt_q   <= '0;
      duty0_q  <= DutyAV;
      duty1_q  <= DutyBV;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[0], bus.sel_raw};
      sel_db_q <= sel_db_d;
      db_cnt_q <= db_cnt_d;
      fcnt_q   <= fcnt_d;
      duty0_q  <= duty0_d;
      duty1_q  <= duty1_d;
      tick_q   <= wrap;
    end
  end

  assign bus.duty0      = duty0_q;
  assign bus.duty1      = duty1_q;
  assign bus.frame_tick = tick_q;
  assign bus.busy       = (state_q == StRamp);

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Directed bench for servo_cmd_ramp with a short frame (100 cycles), step 3, debounce 10.
module tb_servo_cmd_ramp;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  servo_cmd_ramp_if ifc ();

  servo_cmd_ramp #(
    .FRAME_LEN(100),
    .DUTY_A   (40),
    .DUTY_B   (30),
    .STEP     (3),
    .DEBOUNCE (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!ifc.frame_tick && k < 150);
    if (!ifc.frame_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: frame_tick not seen within 150 cycles", name);
    end
  endtask

  // Pulse reset and release it 1 ns after a rising edge; first tick lands 100 edges later.
  task automatic do_reset();
    ifc.sel_raw = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.sel_raw = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.duty0 !== 18'd40) begin n_bad++; $display("FAIL reset_duty0: got %0d want 40", ifc.duty0); end
    n_cmp++; if (ifc.duty1 !== 18'd30) begin n_bad++; $display("FAIL reset_duty1: got %0d want 30", ifc.duty1); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    n_cmp++; if (ifc.frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", ifc.frame_tick); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(99);
    n_cmp++; if (ifc.frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_early: got %b want 0 at edge 99", ifc.frame_tick); end
    cycles(1);
    n_cmp++; if (ifc.frame_tick !== 1'b1) begin n_bad++; $display("FAIL tick_first: got %b want 1 at edge 100", ifc.frame_tick); end
    cycles(1);
    n_cmp++; if (ifc.frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b want 0 at edge 101", ifc.frame_tick); end
    cycles(98);
    n_cmp++; if (ifc.frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_mid: got %b want 0 at edge 199", ifc.frame_tick); end
    cycles(1);
    n_cmp++; if (ifc.frame_tick !== 1'b1) begin n_bad++; $display("FAIL tick_second: got %b want 1 at edge 200", ifc.frame_tick); end
  endtask

  task automatic test_glitch();
    ifc.sel_raw = 1'b1;
    cycles(8);
    ifc.sel_raw = 1'b0;
    cycles(20);
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy: got %b want 0", ifc.busy); end
    for (int i = 0; i < 3; i++) begin
      wait_tick("glitch");
      n_cmp++; if (ifc.duty0 !== 18'd40) begin n_bad++; $display("FAIL glitch_duty0[%0d]: got %0d want 40", i, ifc.duty0); end
      n_cmp++; if (ifc.duty1 !== 18'd30) begin n_bad++; $display("FAIL glitch_duty1[%0d]: got %0d want 30", i, ifc.duty1); end
      n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy[%0d]: got %b want 0", i, ifc.busy); end
    end
  endtask

  task automatic test_select_change();
    int e0[4];
    int e1[4];
    e0 = '{37, 34, 31, 30};
    e1 = '{33, 36, 39, 40};
    ifc.sel_raw = 1'b1;
    cycles(11);
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL sel_busy_early: got %b want 0 after 11", ifc.busy); end
    cycles(1);
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL sel_busy_rise: got %b want 1 after 12", ifc.busy); end
    n_cmp++; if (ifc.duty0 !== 18'd40) begin n_bad++; $display("FAIL sel_duty0_hold: got %0d want 40", ifc.duty0); end
    for (int i = 0; i < 4; i++) begin
      wait_tick("select");
      n_cmp++; if (ifc.duty0 !== 18'(e0[i])) begin n_bad++; $display("FAIL sel_duty0[%0d]: got %0d want %0d", i, ifc.duty0, e0[i]); end
      n_cmp++; if (ifc.duty1 !== 18'(e1[i])) begin n_bad++; $display("FAIL sel_duty1[%0d]: got %0d want %0d", i, ifc.duty1, e1[i]); end
      n_cmp++; if (ifc.busy !== (i < 3)) begin n_bad++; $display("FAIL sel_busy[%0d]: got %b want %b", i, ifc.busy, (i < 3)); end
      if (i == 0) begin
        cycles(50);
        n_cmp++; if (ifc.duty0 !== 18'd37) begin n_bad++; $display("FAIL sel_midframe: got %0d want 37", ifc.duty0); end
      end
    end
  endtask

  task automatic test_reversal();
    do_reset();
    ifc.sel_raw = 1'b1;
    wait_tick("rev_a");
    wait_tick("rev_b");
    n_cmp++; if (ifc.duty0 !== 18'd34) begin n_bad++; $display("FAIL rev_start: got %0d want 34", ifc.duty0); end
    ifc.sel_raw = 1'b0;
    wait_tick("rev_c");
    n_cmp++; if (ifc.duty0 !== 18'd37) begin n_bad++; $display("FAIL rev_duty0_1: got %0d want 37", ifc.duty0); end
    n_cmp++; if (ifc.duty1 !== 18'd33) begin n_bad++; $display("FAIL rev_duty1_1: got %0d want 33", ifc.duty1); end
    n_cmp++; if (ifc.busy !== 1'b1) begin n_bad++; $display("FAIL rev_busy_1: got %b want 1", ifc.busy); end
    wait_tick("rev_d");
    n_cmp++; if (ifc.duty0 !== 18'd40) begin n_bad++; $display("FAIL rev_duty0_2: got %0d want 40", ifc.duty0); end
    n_cmp++; if (ifc.duty1 !== 18'd30) begin n_bad++; $display("FAIL rev_duty1_2: got %0d want 30", ifc.duty1); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rev_busy_2: got %b want 0", ifc.busy); end
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    ifc.sel_raw = 1'b1;
    wait_tick("rst_a");
    wait_tick("rst_b");
    n_cmp++; if (ifc.duty0 !== 18'd34 || ifc.frame_tick !== 1'b1) begin
      n_bad++; $display("FAIL rst_pre: got duty0=%0d tick=%b want 34/1", ifc.duty0, ifc.frame_tick);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ifc.duty0 !== 18'd40) begin n_bad++; $display("FAIL rst_duty0: got %0d want 40", ifc.duty0); end
    n_cmp++; if (ifc.duty1 !== 18'd30) begin n_bad++; $display("FAIL rst_duty1: got %0d want 30", ifc.duty1); end
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
    n_cmp++; if (ifc.frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", ifc.frame_tick); end
  endtask

  // Select lands on the edge 12 after sel_raw changes; aim it at the second wrap edge.
  task automatic test_coincident();
    do_reset();
    wait_tick("coin_a");
    cycles(88);
    ifc.sel_raw = 1'b1;
    cycles(11);
    n_cmp++; if (ifc.busy !== 1'b0) begin n_bad++; $display("FAIL coin_busy_early: got %b want 0", ifc.busy); end
    cycles(1);
    n_cmp++; if (ifc.frame_tick !== 1'b1 || ifc.busy !== 1'b1) begin
      n_bad++; $display("FAIL coin_edge: got tick=%b busy=%b want 1/1", ifc.frame_tick, ifc.busy);
    end
    n_cmp++; if (ifc.duty0 !== 18'd40 || ifc.duty1 !== 18'd30) begin
      n_bad++; $display("FAIL coin_hold: got %0d/%0d want 40/30", ifc.duty0, ifc.duty1);
    end
    wait_tick("coin_b");
    n_cmp++; if (ifc.duty0 !== 18'd37 || ifc.duty1 !== 18'd33) begin
      n_bad++; $display("FAIL coin_step: got %0d/%0d want 37/33", ifc.duty0, ifc.duty1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_glitch();
    test_select_change();
    test_reversal();
    test_reset_mid_ramp();
    test_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/servo_cmd_ramp.md
# servo_cmd_ramp

Command stage directly upstream of the two-channel servo PWM generator. It debounces a raw position-select input and derives a pair of duty-cycle compare values with mirrored targets. The values ramp toward their targets in fixed steps, one step per 20 ms PWM frame, so the servos never jump. Duty outputs change only at frame boundaries, so the downstream PWM never sees a mid-frame compare change.

## Interface
- FRAME_LEN, 240000: clocks per PWM frame (20 ms at 12 MHz); must match the PWM period.
- DUTY_A, 20399: channel-0 target when select=0; channel-1 target when select=1.
- DUTY_B, 15599: channel-0 target when select=1; channel-1 target when select=0.
- STEP, 200: maximum duty change per frame, in clocks.
- DEBOUNCE, 120000: consecutive stable cycles required to accept a select change (10 ms).
- Constraints: DUTY_A, DUTY_B < FRAME_LEN; max(DUTY)+STEP < 2^18; STEP ≥ 1; DEBOUNCE ≥ 1.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sel_raw  in  1  raw select from a switch or button; asynchronous to clk.
- duty0  out  18  channel-0 compare value for the PWM.
- duty1  out  18  channel-1 compare value for the PWM.
- frame_tick  out  1  one-cycle pulse in the first cycle of each frame.
- busy  out  1  high while either duty differs from its target.

## Operation
- Reset values (applied immediately while rst_n=0):
  - duty0=DUTY_A, duty1=DUTY_B.
  - frame_tick=0, busy=0.
  - Frame counter=0, debounce counter=0.
  - Synchronizer flops=0, sel_db=0, state=IDLE.
- Input path: sel_raw passes through a 2-flop synchronizer to sel_sync.
- Debounce counter:
  - Increments while sel_sync≠sel_db.
  - Clears when sel_sync==sel_db.
  - On the DEBOUNCE-th consecutive differing cycle, sel_db←sel_sync and the counter clears.
- Targets are derived from sel_db:
  - sel_db=0: t0=DUTY_A, t1=DUTY_B.
  - sel_db=1: t0=DUTY_B, t1=DUTY_A.
- Frame counter counts 0..FRAME_LEN-1, then wraps to 0. This edge is the "wrap edge".
- On each wrap edge, each duty moves toward its target:
  - If |t−duty| > STEP, duty moves by STEP in the direction of t.
  - Otherwise duty←t; it never overshoots.
  - Arithmetic is unsigned 18-bit; the parameter constraints guarantee no wrap-around.
- FSM states: IDLE and RAMP. busy = (state==RAMP).
  - IDLE→RAMP on the edge where sel_db changes.
  - RAMP→IDLE on the wrap edge whose updated duty0 and duty1 both equal their targets.
  - RAMP holds otherwise.
- Duty values are held constant between wrap edges in every state.
- A target change mid-ramp takes effect at the next wrap edge; each channel reverses direction independently.
- If sel_db flips back before any step has occurred, the FSM may enter RAMP. It then returns to IDLE at the next wrap edge with the duties unchanged.

## Timing
- frame_tick is registered. It is set on the wrap edge and high for exactly one cycle, coincident with counter=0 and the new duty values.
- The first frame_tick after reset release occurs after FRAME_LEN rising edges.
- sel_raw edge → sel_db change: 2 synchronizer cycles + DEBOUNCE cycles. busy rises on the same edge as the sel_db change.
- First duty change occurs at the first wrap edge strictly after the sel_db change.
  - If sel_db changes on a wrap edge, that wrap uses the old targets. The ramp starts on the following frame.
- Full swing takes ceil(|DUTY_A−DUTY_B|/STEP) frames; 24 frames (480 ms) with defaults.
- Asynchronous reset mid-ramp restores all reset values immediately. Counting restarts from 0 after release.

## Test plan
All scenarios use FRAME_LEN=100, DUTY_A=40, DUTY_B=30, STEP=3, DEBOUNCE=10.
- Reset: hold rst_n=0, then release → duty0=40, duty1=30, busy=0; first frame_tick 100 cycles after release, then every 100 cycles, each 1 cycle wide.
- Select change: sel_raw 0→1 and held → busy=1 after 12 cycles. Successive frame_ticks give:
  - duty0: 37, 34, 31, 30.
  - duty1: 33, 36, 39, 40.
  - busy falls with the 4th update.
- Glitch rejection: sel_raw high for 8 cycles, then low → sel_db, duty0/duty1 and busy unchanged for 3 frames.
- Reversal: during the ramp after duty0=34, return sel_raw to 0 → subsequent updates give duty0: 37, 40 and duty1: 33, 30; busy falls after the duty0=40 update.
- Reset mid-ramp: assert rst_n=0 while duty0=34 → duty0=40, duty1=30, busy=0 and frame_tick=0 without waiting for a clock edge.
- Coincident event: time the sel_db change onto a wrap edge → duties unchanged at that wrap, first step at the next frame_tick.
